// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard/stall controller for the 5-stage pipeline
// Drives PC and stage-register write enables, NOP bubble strobes and a stall counter.
module pipeline_ctrl #(
    parameter int MUL_CYCLES  = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  i_fd_rs,
    input  logic [4:0]  i_fd_rt,
    input  logic        i_fd_uses_rs,
    input  logic        i_fd_uses_rt,
    input  logic        i_de_mem_read,
    input  logic [4:0]  i_de_dst_reg,
    input  logic        i_de_muldiv_start,
    input  logic        i_de_muldiv_is_div,
    input  logic        i_em_mem_req,
    input  logic        i_mem_ack,
    input  logic        i_em_redirect,
    input  logic        i_imem_ready,
    output logic        o_pc_wren,
    output logic        o_fd_wren,
    output logic        o_de_wren,
    output logic        o_em_wren,
    output logic        o_mw_wren,
    output logic        o_fd_bubble,
    output logic        o_de_bubble,
    output logic        o_em_bubble,
    output logic        o_mw_bubble,
    output logic        o_muldiv_busy,
    output logic        o_muldiv_done,
    output logic        o_mem_error,
    output logic [31:0] o_stall_cnt
);

    localparam int MD_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int MDW    = $clog2(MD_MAX + 1);
    localparam int MCW    = $clog2(MEM_TIMEOUT + 1);

    localparam logic [MDW-1:0] MD_MUL_LOAD = MDW'(MUL_CYCLES - 1);
    localparam logic [MDW-1:0] MD_DIV_LOAD = MDW'(DIV_CYCLES - 1);
    localparam logic [MCW-1:0] MEM_LIMIT   = MCW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MD_BUSY  = 2'd1,
        S_MEM_WAIT = 2'd2
    } state_t;

    state_t          r_state;
    logic [MDW-1:0]  r_md_cnt;
    logic [MCW-1:0]  r_mem_cnt;
    logic            r_mem_error;
    logic [31:0]     r_stall_cnt;

    logic w_mem_stall;
    logic w_load_use;
    logic w_rs_hit;
    logic w_rt_hit;
    logic w_mem_timeout;
    logic w_mem_release;

    logic w_pc_wren;
    logic w_fd_wren;
    logic w_de_wren;
    logic w_em_wren;
    logic w_mw_wren;
    logic w_fd_bubble;
    logic w_de_bubble;
    logic w_em_bubble;
    logic w_mw_bubble;
    logic w_muldiv_busy;
    logic w_muldiv_done;

    assign w_mem_stall   = i_em_mem_req & ~i_mem_ack;
    assign w_rs_hit      = i_fd_uses_rs & (i_fd_rs == i_de_dst_reg);
    assign w_rt_hit      = i_fd_uses_rt & (i_fd_rt == i_de_dst_reg);
    assign w_load_use    = i_de_mem_read & (i_de_dst_reg != 5'd0) & (w_rs_hit | w_rt_hit);
    // An ack arriving on the timeout cycle counts as a normal completion.
    assign w_mem_timeout = ~i_mem_ack & (r_mem_cnt == MEM_LIMIT);
    assign w_mem_release = i_mem_ack | (r_mem_cnt == MEM_LIMIT);

    always_comb begin
        w_pc_wren     = 1'b1;
        w_fd_wren     = 1'b1;
        w_de_wren     = 1'b1;
        w_em_wren     = 1'b1;
        w_mw_wren     = 1'b1;
        w_fd_bubble   = 1'b0;
        w_de_bubble   = 1'b0;
        w_em_bubble   = 1'b0;
        w_mw_bubble   = 1'b0;
        w_muldiv_busy = 1'b0;
        w_muldiv_done = 1'b0;
        if (!reset_n) begin
            w_pc_wren = 1'b0;
            w_fd_wren = 1'b0;
            w_de_wren = 1'b0;
            w_em_wren = 1'b0;
            w_mw_wren = 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    // Priority: oldest stage first, so MEM events mask younger ID/EX events.
                    if (w_mem_stall) begin
                        w_pc_wren   = 1'b0;
                        w_fd_wren   = 1'b0;
                        w_de_wren   = 1'b0;
                        w_em_wren   = 1'b0;
                        w_mw_bubble = 1'b1;
                    end else if (i_em_redirect) begin
                        w_fd_bubble = 1'b1;
                        w_de_bubble = 1'b1;
                        w_em_bubble = 1'b1;
                    end else if (i_de_muldiv_start) begin
                        w_pc_wren   = 1'b0;
                        w_fd_wren   = 1'b0;
                        w_de_wren   = 1'b0;
                        w_em_bubble = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_wren   = 1'b0;
                        w_fd_wren   = 1'b0;
                        w_de_bubble = 1'b1;
                    end else if (!i_imem_ready) begin
                        w_pc_wren   = 1'b0;
                        w_fd_bubble = 1'b1;
                    end
                end
                S_MD_BUSY: begin
                    w_muldiv_busy = 1'b1;
                    if (r_md_cnt != '0) begin
                        w_pc_wren   = 1'b0;
                        w_fd_wren   = 1'b0;
                        w_de_wren   = 1'b0;
                        w_em_bubble = 1'b1;
                    end else begin
                        w_muldiv_done = 1'b1;
                    end
                end
                S_MEM_WAIT: begin
                    if (!w_mem_release) begin
                        w_pc_wren   = 1'b0;
                        w_fd_wren   = 1'b0;
                        w_de_wren   = 1'b0;
                        w_em_wren   = 1'b0;
                        w_mw_bubble = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_RUN;
            r_md_cnt    <= '0;
            r_mem_cnt   <= '0;
            r_mem_error <= 1'b0;
            r_stall_cnt <= 32'd0;
        end else begin
            if (!w_pc_wren) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            case (r_state)
                S_RUN: begin
                    if (w_mem_stall) begin
                        r_state   <= S_MEM_WAIT;
                        r_mem_cnt <= MCW'(1);
                    end else if (!i_em_redirect && i_de_muldiv_start) begin
                        r_state  <= S_MD_BUSY;
                        r_md_cnt <= i_de_muldiv_is_div ? MD_DIV_LOAD : MD_MUL_LOAD;
                    end
                end
                S_MD_BUSY: begin
                    if (r_md_cnt == '0) begin
                        r_state <= S_RUN;
                    end else begin
                        r_md_cnt <= r_md_cnt - MDW'(1);
                    end
                end
                S_MEM_WAIT: begin
                    if (w_mem_release) begin
                        r_state   <= S_RUN;
                        r_mem_cnt <= '0;
                        if (w_mem_timeout) begin
                            r_mem_error <= 1'b1;
                        end
                    end else begin
                        r_mem_cnt <= r_mem_cnt + MCW'(1);
                    end
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    assign o_pc_wren     = w_pc_wren;
    assign o_fd_wren     = w_fd_wren;
    assign o_de_wren     = w_de_wren;
    assign o_em_wren     = w_em_wren;
    assign o_mw_wren     = w_mw_wren;
    assign o_fd_bubble   = w_fd_bubble;
    assign o_de_bubble   = w_de_bubble;
    assign o_em_bubble   = w_em_bubble;
    assign o_mw_bubble   = w_mw_bubble;
    assign o_muldiv_busy = w_muldiv_busy;
    assign o_muldiv_done = w_muldiv_done;
    assign o_mem_error   = r_mem_error;
    assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed and randomized checks of pipeline_ctrl against a reference model
module tb_pipeline_ctrl;

    localparam int MUL_N = 4;
    localparam int DIV_N = 32;
    localparam int TMO_N = 255;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  fd_rs, fd_rt, de_dst_reg;
    logic        fd_uses_rs, fd_uses_rt, de_mem_read, de_muldiv_start, de_muldiv_is_div;
    logic        em_mem_req, mem_ack, em_redirect, imem_ready;
    logic        pc_wren, fd_wren, de_wren, em_wren, mw_wren;
    logic        fd_bubble, de_bubble, em_bubble, mw_bubble;
    logic        muldiv_busy, muldiv_done, mem_error;
    logic [31:0] stall_cnt;

    pipeline_ctrl #(
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N),
        .MEM_TIMEOUT(TMO_N)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .i_fd_rs           (fd_rs),
        .i_fd_rt           (fd_rt),
        .i_fd_uses_rs      (fd_uses_rs),
        .i_fd_uses_rt      (fd_uses_rt),
        .i_de_mem_read     (de_mem_read),
        .i_de_dst_reg      (de_dst_reg),
        .i_de_muldiv_start (de_muldiv_start),
        .i_de_muldiv_is_div(de_muldiv_is_div),
        .i_em_mem_req      (em_mem_req),
        .i_mem_ack         (mem_ack),
        .i_em_redirect     (em_redirect),
        .i_imem_ready      (imem_ready),
        .o_pc_wren         (pc_wren),
        .o_fd_wren         (fd_wren),
        .o_de_wren         (de_wren),
        .o_em_wren         (em_wren),
        .o_mw_wren         (mw_wren),
        .o_fd_bubble       (fd_bubble),
        .o_de_bubble       (de_bubble),
        .o_em_bubble       (em_bubble),
        .o_mw_bubble       (mw_bubble),
        .o_muldiv_busy     (muldiv_busy),
        .o_muldiv_done     (muldiv_done),
        .o_mem_error       (mem_error),
        .o_stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: remaining EX occupancy cycles and elapsed memory wait cycles.
    int          m_md_left = 0;
    int          m_mem_k   = 0;
    logic        m_mem_err = 1'b0;
    logic [31:0] m_stall   = 32'd0;

    logic s_pc, s_fd, s_de, s_em, s_mw, s_fdb, s_deb, s_emb, s_mwb, s_busy, s_done, s_err;
    logic [31:0] s_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        fd_rs = 5'd0; fd_rt = 5'd0; de_dst_reg = 5'd0;
        fd_uses_rs = 1'b0; fd_uses_rt = 1'b0; de_mem_read = 1'b0;
        de_muldiv_start = 1'b0; de_muldiv_is_div = 1'b0;
        em_mem_req = 1'b0; mem_ack = 1'b0; em_redirect = 1'b0; imem_ready = 1'b1;
    endtask

    // One clock: compare DUT against model at negedge, then advance the model at posedge.
    task automatic cycle();
        logic [4:0] wr;
        logic [3:0] bb;
        logic       busy, done, lu, timed_out;
        @(negedge clk);
        wr = 5'b11111; bb = 4'b0000; busy = 1'b0; done = 1'b0; timed_out = 1'b0;
        lu = de_mem_read && de_dst_reg != 0 &&
             ((fd_uses_rs && fd_rs == de_dst_reg) || (fd_uses_rt && fd_rt == de_dst_reg));
        if (!reset_n) begin
            wr = 5'b00000;
        end else if (m_md_left > 0) begin
            busy = 1'b1;
            if (m_md_left == 1) done = 1'b1;
            else begin wr = 5'b00011; bb = 4'b0010; end
        end else if (m_mem_k > 0) begin
            timed_out = !mem_ack && m_mem_k == TMO_N;
            if (!mem_ack && m_mem_k < TMO_N) begin wr = 5'b00001; bb = 4'b0001; end
        end else if (em_mem_req && !mem_ack) begin
            wr = 5'b00001; bb = 4'b0001;
        end else if (em_redirect) begin
            bb = 4'b1110;
        end else if (de_muldiv_start) begin
            wr = 5'b00011; bb = 4'b0010;
        end else if (lu) begin
            wr = 5'b00111; bb = 4'b0100;
        end else if (!imem_ready) begin
            wr = 5'b01111; bb = 4'b1000;
        end
        check("outputs", {21'd0, pc_wren, fd_wren, de_wren, em_wren, mw_wren,
                          fd_bubble, de_bubble, em_bubble, mw_bubble, muldiv_busy, muldiv_done},
                         {21'd0, wr, bb, busy, done});
        check("stall_cnt", stall_cnt, m_stall);
        check("mem_error", {31'd0, mem_error}, {31'd0, m_mem_err});
        {s_pc, s_fd, s_de, s_em, s_mw} = {pc_wren, fd_wren, de_wren, em_wren, mw_wren};
        {s_fdb, s_deb, s_emb, s_mwb} = {fd_bubble, de_bubble, em_bubble, mw_bubble};
        {s_busy, s_done, s_err} = {muldiv_busy, muldiv_done, mem_error};
        s_stall = stall_cnt;
        @(posedge clk);
        if (!reset_n) begin
            m_md_left = 0; m_mem_k = 0; m_mem_err = 1'b0; m_stall = 32'd0;
        end else begin
            if (!wr[4]) m_stall = m_stall + 32'd1;
            if (m_md_left > 0) m_md_left--;
            else if (m_mem_k > 0) begin
                if (mem_ack || m_mem_k == TMO_N) m_mem_k = 0;
                else m_mem_k++;
                if (timed_out) m_mem_err = 1'b1;
            end else if (em_mem_req && !mem_ack) m_mem_k = 1;
            else if (!em_redirect && de_muldiv_start)
                m_md_left = de_muldiv_is_div ? DIV_N : MUL_N;
        end
        #1;
    endtask

    initial begin
        int n_st, n_busy, n_done, last_done, n_mwb, n_wait, released, n_if;
        clear_inputs();
        reset_n = 1'b0;
        #1;
        cycle(); cycle();
        reset_n = 1'b1;
        cycle();
        check("rst_stall", s_stall, 32'd0);

        // load-use on rs, then the same with a zero destination
        de_mem_read = 1'b1; de_dst_reg = 5'd3; fd_rs = 5'd3; fd_uses_rs = 1'b1;
        cycle();
        check("lu_pc_fd", {30'd0, s_pc, s_fd}, 32'd0);
        check("lu_deb", {31'd0, s_deb}, 32'd1);
        clear_inputs();
        cycle();
        check("lu_stall", s_stall, 32'd1);
        de_mem_read = 1'b1; de_dst_reg = 5'd0; fd_rs = 5'd0; fd_uses_rs = 1'b1;
        cycle();
        check("lu_zero_pc", {31'd0, s_pc}, 32'd1);
        clear_inputs();

        // divide with start held high for the whole occupancy
        de_muldiv_start = 1'b1; de_muldiv_is_div = 1'b1;
        n_st = 0; n_busy = 0; n_done = 0; last_done = 0;
        for (int i = 0; i < DIV_N + 1; i++) begin
            cycle();
            if (!s_pc && !s_fd && !s_de) n_st++;
            if (s_busy) n_busy++;
            if (s_done) n_done++;
            if (i == DIV_N) last_done = int'(s_done);
        end
        clear_inputs();
        cycle();
        check("div_stalls", n_st, DIV_N);
        check("div_busy", n_busy, DIV_N);
        check("div_done_cnt", n_done, 1);
        check("div_done_last", last_done, 1);
        check("div_after_busy", {31'd0, s_busy}, 32'd0);
        check("div_stall_cnt", s_stall, 32'd33);

        // memory ack after 5 wait cycles
        em_mem_req = 1'b1;
        n_mwb = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (s_mwb && s_mw && !s_pc) n_mwb++;
        end
        mem_ack = 1'b1;
        cycle();
        check("mem_release", {26'd0, s_pc, s_fd, s_de, s_em, s_mw, s_mwb}, 32'b111110);
        clear_inputs();
        cycle();
        check("mem_bubbles", n_mwb, 5);
        check("mem_stall_cnt", s_stall, 32'd38);
        check("mem_no_err", {31'd0, s_err}, 32'd0);

        // no ack: forced release on timeout
        em_mem_req = 1'b1;
        n_wait = 0; released = 0;
        for (int i = 0; i < TMO_N + 40 && released == 0; i++) begin
            cycle();
            if (s_pc) released = 1;
            else n_wait++;
        end
        clear_inputs();
        check("to_released", released, 1);
        check("to_stalls", n_wait, TMO_N);
        cycle(); cycle(); cycle();
        check("to_err_sticky", {31'd0, s_err}, 32'd1);

        // redirect beats load-use and mul/div
        em_redirect = 1'b1; de_muldiv_start = 1'b1;
        de_mem_read = 1'b1; de_dst_reg = 5'd7; fd_rt = 5'd7; fd_uses_rt = 1'b1;
        cycle();
        check("rd_wren", {27'd0, s_pc, s_fd, s_de, s_em, s_mw}, 32'b11111);
        check("rd_bubbles", {28'd0, s_fdb, s_deb, s_emb, s_mwb}, 32'b1110);
        clear_inputs();
        cycle();
        check("rd_stays_run", {30'd0, s_busy, s_pc}, 32'b01);
        check("rd_stall_cnt", s_stall, 32'd293);

        // reset in the middle of a divide (md_cnt at 10)
        de_muldiv_start = 1'b1; de_muldiv_is_div = 1'b1;
        for (int i = 0; i < 22; i++) cycle();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        clear_inputs();
        cycle();
        check("rst_md_busy", {31'd0, s_busy}, 32'd0);
        check("rst_md_stall", s_stall, 32'd0);
        check("rst_md_err", {31'd0, s_err}, 32'd0);

        // instruction memory not ready for 3 cycles
        imem_ready = 1'b0;
        n_if = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (!s_pc && s_fdb) n_if++;
        end
        imem_ready = 1'b1;
        cycle();
        check("if_wait_cycles", n_if, 3);
        check("if_stall_cnt", s_stall, 32'd3);

        // randomized traffic checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            reset_n          = ($urandom_range(0, 99) != 0);
            fd_rs            = 5'($urandom_range(0, 3));
            fd_rt            = 5'($urandom_range(0, 3));
            de_dst_reg       = 5'($urandom_range(0, 3));
            fd_uses_rs       = 1'($urandom_range(0, 1));
            fd_uses_rt       = 1'($urandom_range(0, 1));
            de_mem_read      = 1'($urandom_range(0, 1));
            de_muldiv_start  = ($urandom_range(0, 7) == 0);
            de_muldiv_is_div = ($urandom_range(0, 3) == 0);
            em_mem_req       = ($urandom_range(0, 3) == 0);
            mem_ack          = ($urandom_range(0, 2) == 0);
            em_redirect      = ($urandom_range(0, 7) == 0);
            imem_ready       = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
